// File: rtl/chrom_eval_engine.sv
// chrom_eval_engine: drives stimulus into a phenotype, compares outputs, accumulates saturating per-bit errors and streams a trace.
// Optional EARLY_ABORT_EN: stop at the end of the first hold window that saw an error.
module chrom_eval_engine #(
  parameter int IN_WIDTH      = 8,
  parameter int OUT_WIDTH     = 8,
  parameter int MAX_SAMPLES   = 64,
  parameter int CNT_WIDTH     = 16,
  parameter int IGNORE_CYCLES = 4,
  parameter int ZERO_CYCLES   = 2,
  parameter int NUM_RETRIES   = 3,
  parameter int TRACE_AW      = 15
) (
  input  logic                             iClock,
  input  logic                             iReset,
  input  logic                             iStart,
  input  logic                             iAck,
  input  logic                             iAbort,
  input  logic [15:0]                      iHoldCycles,
  input  logic [7:0]                       iNumSamples,
  input  logic [MAX_SAMPLES*IN_WIDTH-1:0]  iInputSeq,
  input  logic [MAX_SAMPLES*OUT_WIDTH-1:0] iExpected,
  input  logic [MAX_SAMPLES*OUT_WIDTH-1:0] iValidMask,
  input  logic [OUT_WIDTH-1:0]             iChromOut,
  output logic [IN_WIDTH-1:0]              oChromIn,
  output logic                             oChromZero,
  output logic                             oReady,
  output logic                             oDone,
  output logic                             oPass,
  output logic                             oAborted,
  output logic [OUT_WIDTH*CNT_WIDTH-1:0]   oErrorSums,
  output logic [CNT_WIDTH+7:0]             oTotalErrors,
  output logic [2:0]                       oState,
  output logic                             oTraceWe,
  output logic [TRACE_AW-1:0]              oTraceAddr,
  output logic [IN_WIDTH+8+2*OUT_WIDTH-1:0] oTraceData
);
  typedef enum logic [2:0] {IDLE = 3'd0, ZERO = 3'd1, APPLY = 3'd2, CHECK = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [7:0] n_q, n_d, idx_q, idx_d, retry_q, retry_d, zcnt_q, zcnt_d;
  logic [15:0] h_q, h_d, c_q, c_d;
  logic [OUT_WIDTH-1:0] flag_q, flag_d, flag_upd, exp_cur, vld_cur;
  logic [OUT_WIDTH-1:0][CNT_WIDTH-1:0] sums_q, sums_d, sums_acc;
  logic [IN_WIDTH-1:0] chrom_q, chrom_d, vec0, vec_nxt;
  logic [TRACE_AW-1:0] taddr_q, taddr_d;
  logic pass_q, pass_d, abort_q, abort_d, last_c, early;
  logic [CNT_WIDTH+7:0] total;
  assign exp_cur  = iExpected[int'(idx_q)*OUT_WIDTH +: OUT_WIDTH];
  assign vld_cur  = iValidMask[int'(idx_q)*OUT_WIDTH +: OUT_WIDTH];
  assign vec0     = iInputSeq[IN_WIDTH-1:0];
  assign vec_nxt  = iInputSeq[int'(idx_q + 8'd1)*IN_WIDTH +: IN_WIDTH];
  assign flag_upd = flag_q | ((c_q >= 16'(IGNORE_CYCLES)) ? ((iChromOut ^ exp_cur) & vld_cur) : '0);
  assign last_c   = c_q == h_q - 16'd1;
`ifdef EARLY_ABORT_EN
  assign early = |flag_upd;
`else
  assign early = 1'b0;
`endif
  always_comb begin
    total = '0;
    for (int b = 0; b < OUT_WIDTH; b++) begin
      sums_acc[b] = (flag_upd[b] && sums_q[b] != '1) ? sums_q[b] + CNT_WIDTH'(1) : sums_q[b];
      total = total + (CNT_WIDTH+8)'(sums_q[b]);
    end
  end
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    h_d     = h_q;
    c_d     = c_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    zcnt_d  = zcnt_q;
    flag_d  = flag_q;
    sums_d  = sums_q;
    chrom_d = chrom_q;
    taddr_d = taddr_q;
    pass_d  = pass_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: if (iStart) begin
        n_d     = (iNumSamples == 8'd0) ? 8'd1 : (iNumSamples > 8'(MAX_SAMPLES)) ? 8'(MAX_SAMPLES) : iNumSamples;
        h_d     = (iHoldCycles < 16'(IGNORE_CYCLES + 1)) ? 16'(IGNORE_CYCLES + 1) : iHoldCycles;
        sums_d  = '0;
        retry_d = '0;
        idx_d   = '0;
        zcnt_d  = '0;
        pass_d  = 1'b0;
        abort_d = 1'b0;
        state_d = ZERO;
      end
      ZERO: begin
        zcnt_d = zcnt_q + 8'd1;
        if (zcnt_q >= 8'(ZERO_CYCLES - 1)) begin
          chrom_d = vec0;
          c_d     = '0;
          flag_d  = '0;
          taddr_d = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        taddr_d = taddr_q + TRACE_AW'(1);
        flag_d  = flag_upd;
        c_d     = c_q + 16'd1;
        if (last_c) begin
          sums_d = sums_acc;
          c_d    = '0;
          flag_d = '0;
          if (early) state_d = DONE;
          else if (idx_q == n_q - 8'd1) state_d = CHECK;
          else begin
            idx_d   = idx_q + 8'd1;
            chrom_d = vec_nxt;
          end
        end
      end
      CHECK: begin
        if (total != '0) state_d = DONE;
        else if (retry_q < 8'(NUM_RETRIES)) begin
          retry_d = retry_q + 8'd1;
          idx_d   = '0;
          taddr_d = '0;
          chrom_d = vec0;
          c_d     = '0;
          flag_d  = '0;
          state_d = APPLY;
        end else begin
          pass_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (iAck) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort beats everything and drops the partially accumulated window
    if (iAbort && (state_q == ZERO || state_q == APPLY || state_q == CHECK)) begin
      state_d = DONE;
      abort_d = 1'b1;
      pass_d  = 1'b0;
      sums_d  = sums_q;
    end
  end
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
      n_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      zcnt_q  <= '0;
      flag_q  <= '0;
      sums_q  <= '0;
      chrom_q <= '0;
      taddr_q <= '0;
      pass_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      h_q     <= h_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      zcnt_q  <= zcnt_d;
      flag_q  <= flag_d;
      sums_q  <= sums_d;
      chrom_q <= chrom_d;
      taddr_q <= taddr_d;
      pass_q  <= pass_d;
      abort_q <= abort_d;
    end
  end
  assign oChromIn     = chrom_q;
  assign oChromZero   = state_q == ZERO;
  assign oReady       = state_q == IDLE;
  assign oDone        = state_q == DONE;
  assign oPass        = pass_q;
  assign oAborted     = abort_q;
  assign oErrorSums   = sums_q;
  assign oTotalErrors = total;
  assign oState       = state_q;
  assign oTraceWe     = state_q == APPLY;
  assign oTraceAddr   = taddr_q;
  assign oTraceData   = {chrom_q, idx_q, exp_cur, iChromOut};
endmodule

// File: doc/chrom_eval_engine.md
Name: chrom_eval_engine

Overview:
Parametrised evaluation controller for one evolved chromosome. It drives a sequence of stimulus vectors into the phenotype and holds each vector for a programmable window. During that window it samples the phenotype output against the expected and valid masks, and accumulates a saturating per-output-bit error count. A zero-error pass is repeated for a set number of retries, and every sampled cycle is streamed to a trace RAM. It sits between the GA host controller (start/ack handshake) and the phenotype instance.

Parameters:
IN_WIDTH, 8, phenotype input width
OUT_WIDTH, 8, phenotype output width (number of error counters)
MAX_SAMPLES, 64, stimulus vectors held in the flattened input buses
CNT_WIDTH, 16, width of each error counter (saturating)
IGNORE_CYCLES, 4, settle cycles at the start of each hold window that are not compared
ZERO_CYCLES, 2, cycles the phenotype is driven with an all-zero chromosome before the first sample
NUM_RETRIES, 3, extra full passes run after a zero-error pass
TRACE_AW, 15, trace RAM address width

Ports:
iClock  in  1  clock, rising edge
iReset  in  1  synchronous, active-high reset
iStart  in  1  start request; honoured only in IDLE
iAck  in  1  host acknowledge of DONE
iAbort  in  1  abort current evaluation
iHoldCycles  in  16  hold window length per sample; latched at start
iNumSamples  in  8  vectors per pass; latched at start
iInputSeq  in  MAX_SAMPLES*IN_WIDTH  stimulus; vector k at bits [k*IN_WIDTH +: IN_WIDTH]
iExpected  in  MAX_SAMPLES*OUT_WIDTH  expected outputs, same packing
iValidMask  in  MAX_SAMPLES*OUT_WIDTH  1 = bit is compared
iChromOut  in  OUT_WIDTH  phenotype output
oChromIn  out  IN_WIDTH  registered phenotype input
oChromZero  out  1  force chromosome description to zero
oReady  out  1  state == IDLE
oDone  out  1  state == DONE
oPass  out  1  valid in DONE: all passes error-free and not aborted
oAborted  out  1  valid in DONE: evaluation ended by iAbort
oErrorSums  out  OUT_WIDTH*CNT_WIDTH  per-bit error counts
oTotalErrors  out  CNT_WIDTH+8  sum of all counters
oState  out  3  state encoding
oTraceWe  out  1  trace write strobe
oTraceAddr  out  TRACE_AW  trace address
oTraceData  out  IN_WIDTH+8+2*OUT_WIDTH  {oChromIn, sample index, expected, iChromOut}

Behaviour:
- Reset (synchronous): state IDLE; all counters, sums, index, oChromIn, oTraceAddr = 0; oPass, oAborted, oTraceWe = 0.
- States: IDLE=0, ZERO=1, APPLY=2, CHECK=3, DONE=4.
- IDLE + iStart: latch N = clamp(iNumSamples, 1, MAX_SAMPLES) and H = max(iHoldCycles, IGNORE_CYCLES+1). Clear the sums, retry count and index. Enter ZERO on the next edge.
- ZERO: oChromZero=1 for exactly ZERO_CYCLES cycles. On exit, load oChromIn = vector 0, clear cycle counter and sample flags, set oTraceAddr=0, go to APPLY.
- APPLY: cycle counter c runs 0..H-1.
  - For c >= IGNORE_CYCLES: flag[b] |= (iChromOut[b] ^ exp[b]) & valid[b].
  - Edge ending c=H-1: the comparison from that same cycle is included. Each sum[b] += flag[b], saturating at 2^CNT_WIDTH-1. If index == N-1, go to CHECK; otherwise index+1, load the next oChromIn, clear c and the flags, stay in APPLY.
- Trace: oTraceWe=1 on every APPLY cycle, and oTraceAddr increments after each write. Addresses wrap modulo 2^TRACE_AW with no stall. oTraceAddr returns to 0 at the start of each pass.
- CHECK (1 cycle):
  - oTotalErrors != 0: go to DONE with oPass=0.
  - Otherwise, if retries done < NUM_RETRIES: retry+1, index=0, oTraceAddr=0, go to APPLY. ZERO is not re-entered.
  - Otherwise: go to DONE with oPass=1.
- DONE: outputs are held. iAck moves to IDLE on the next edge. oErrorSums stay valid until the next iStart.
- iAbort in ZERO, APPLY or CHECK: go to DONE next edge with oAborted=1 and oPass=0. The partial window is discarded. iAbort has priority over every other transition; it is ignored in IDLE and DONE.
- iStart outside IDLE is ignored. iStart and iAck asserted together in DONE: go to IDLE only; a new start needs iStart again.
- oTotalErrors is combinational over the registered sums, zero-extended.

Optional Feature:
EARLY_ABORT_EN
- Defined: at the end of any hold window where some flag[b]=1, the engine goes straight to DONE with oPass=0 and does not finish the pass. The sums reflect samples up to and including that one.
- Undefined: all N samples are always evaluated.

Test Plan:
- N=4, H=10, expected = phenotype output on every sample -> 4 passes (1+3 retries), 160 trace writes, DONE with oPass=1 and all sums 0.
- N=3, H=8, bit 2 wrong from c=5 of sample 1 -> sum[2]=1, other sums 0, DONE after 1 pass with oPass=0.
- Output bit wrong only in c<4 (ignored cycles) -> no error counted; bit wrong only at c=H-1 -> 1 error counted.
- iAbort asserted at c=3 of sample 2 -> DONE next edge with oAborted=1, oPass=0; iAck -> IDLE.
- CNT_WIDTH=2, bit 0 wrong on all 6 samples -> sum[0] saturates at 3.
- With EARLY_ABORT_EN: N=5, error on sample 1 -> DONE after sample 1, with no trace writes for samples 2-4.
